// File: rtl/split_from_noc.sv
// Receive-side NoC demultiplexer: steers whole packets to a header or payload output.
// Each output has a 2-entry registered buffer; malformed input beats are dropped and counted.
module split_from_noc #(
    parameter int DATA_WIDTH = 64,
    localparam int EMPTY_W = $clog2(DATA_WIDTH/8)
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic                  in_error,
    input  logic [EMPTY_W-1:0]    in_empty,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  i_payload_in,

    output logic                  out_header_valid,
    input  logic                  out_header_ready,
    output logic                  out_header_sop,
    output logic                  out_header_eop,
    output logic                  out_header_error,
    output logic [EMPTY_W-1:0]    out_header_empty,
    output logic [DATA_WIDTH-1:0] out_header_data,

    output logic                  out_payload_valid,
    input  logic                  out_payload_ready,
    output logic                  out_payload_sop,
    output logic                  out_payload_eop,
    output logic                  out_payload_error,
    output logic [EMPTY_W-1:0]    out_payload_empty,
    output logic [DATA_WIDTH-1:0] out_payload_data,

    output logic [15:0]           o_hdr_pkts,
    output logic [15:0]           o_pay_pkts,
    output logic [15:0]           o_drop_beats
);

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, DROP} state_t;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic                  error;
        logic [EMPTY_W-1:0]    empty;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    localparam int H = 0;
    localparam int P = 1;

    state_t     state, state_next;
    logic       ready_en;
    beat_t      fifo [2][2];
    logic [1:0] cnt [2];
    logic [1:0] push, pop, out_ready;
    beat_t      in_beat, push_beat;
    logic       accept, drop;

    assign out_ready = {out_payload_ready, out_header_ready};
    assign in_beat   = {in_sop, in_eop, in_error, in_empty, in_data};

    // ready_en keeps in_ready low during reset and until the first clock after release
    always_comb begin
        case (state)
            HEAD:    in_ready = ready_en && (cnt[H] != 2'd2);
            PAYLOAD: in_ready = ready_en && (cnt[P] != 2'd2);
            default: in_ready = ready_en && (cnt[H] != 2'd2) && (cnt[P] != 2'd2);
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        for (int i = 0; i < 2; i++) pop[i] = (cnt[i] != 2'd0) && out_ready[i];
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        push       = '0;
        drop       = 1'b0;
        push_beat  = in_beat;
        state_next = state;
        if (accept) begin
            case (state)
                HEAD, PAYLOAD: begin
                    if (state == PAYLOAD) push[P] = 1'b1;
                    else                  push[H] = 1'b1;
                    if (in_sop) begin
                        push_beat.sop   = 1'b0;
                        push_beat.error = 1'b1;
                    end
                    if (in_eop) state_next = IDLE;
                end
                default: begin
                    if (in_sop) begin
                        push[i_payload_in] = 1'b1;
                        state_next = in_eop ? IDLE : (i_payload_in ? PAYLOAD : HEAD);
                    end else begin
                        drop       = 1'b1;
                        state_next = in_eop ? IDLE : DROP;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ready_en     <= 1'b0;
            o_hdr_pkts   <= '0;
            o_pay_pkts   <= '0;
            o_drop_beats <= '0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
            if (pop[H] && fifo[H][0].eop) o_hdr_pkts   <= o_hdr_pkts + 16'd1;
            if (pop[P] && fifo[P][0].eop) o_pay_pkts   <= o_pay_pkts + 16'd1;
            if (drop)                     o_drop_beats <= o_drop_beats + 16'd1;
        end
    end

    // NOTE: the buffer entries are reset because the head entry drives the outputs directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo[i][0] <= '0;
                fifo[i][1] <= '0;
                cnt[i]     <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                // entry 0 is always the head; entry 1 shifts down on pop
                case ({push[i], pop[i]})
                    2'b10: begin
                        if (cnt[i] == 2'd0) fifo[i][0] <= push_beat;
                        else                fifo[i][1] <= push_beat;
                        cnt[i] <= cnt[i] + 2'd1;
                    end
                    2'b01: begin
                        fifo[i][0] <= fifo[i][1];
                        cnt[i]     <= cnt[i] - 2'd1;
                    end
                    2'b11: fifo[i][0] <= push_beat;
                    default: ;
                endcase
            end
        end
    end

    assign out_header_valid  = (cnt[H] != 2'd0);
    assign out_header_sop    = fifo[H][0].sop;
    assign out_header_eop    = fifo[H][0].eop;
    assign out_header_error  = fifo[H][0].error;
    assign out_header_empty  = fifo[H][0].empty;
    assign out_header_data   = fifo[H][0].data;

    assign out_payload_valid = (cnt[P] != 2'd0);
    assign out_payload_sop   = fifo[P][0].sop;
    assign out_payload_eop   = fifo[P][0].eop;
    assign out_payload_error = fifo[P][0].error;
    assign out_payload_empty = fifo[P][0].empty;
    assign out_payload_data  = fifo[P][0].data;

endmodule

// File: tb/tb_split_from_noc.sv
// Self-checking bench for split_from_noc: directed scenarios plus randomized packets
// checked against a packet-level reference model held in queues.
module tb_split_from_noc;

    localparam int DW = 64;
    localparam int EW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_error = 1'b0;
    logic [EW-1:0] in_empty = '0;
    logic [DW-1:0] in_data = '0;
    logic          i_payload_in = 1'b0;
    logic          in_ready;
    logic          hdr_rdy = 1'b1, pay_rdy = 1'b1;
    logic          hv, hs, he, herr, pv, ps, pe, perr;
    logic [EW-1:0] hemp, pemp;
    logic [DW-1:0] hdat, pdat;
    logic [15:0]   o_hdr_pkts, o_pay_pkts, o_drop_beats;

    always #5 clk = ~clk;

    split_from_noc #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
        .in_error(in_error), .in_empty(in_empty), .in_data(in_data), .i_payload_in(i_payload_in),
        .out_header_valid(hv), .out_header_ready(hdr_rdy), .out_header_sop(hs),
        .out_header_eop(he), .out_header_error(herr), .out_header_empty(hemp), .out_header_data(hdat),
        .out_payload_valid(pv), .out_payload_ready(pay_rdy), .out_payload_sop(ps),
        .out_payload_eop(pe), .out_payload_error(perr), .out_payload_empty(pemp), .out_payload_data(pdat),
        .o_hdr_pkts(o_hdr_pkts), .o_pay_pkts(o_pay_pkts), .o_drop_beats(o_drop_beats)
    );

    typedef struct {
        logic          sop, eop, err;
        logic [EW-1:0] empty;
        logic [DW-1:0] data;
    } mbeat_t;

    mbeat_t qh[$], qp[$];
    int     nerr = 0, nchk = 0;
    int     m_mode = 0;   // 0: between packets, 1: inside a packet, 2: discarding
    logic   m_dest = 1'b0;
    int     exp_hdr = 0, exp_pay = 0, exp_drop = 0;
    bit     rand_rdy = 1'b0;
    int     w, wsum;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] pk(input mbeat_t b);
        return {10'd0, b.sop, b.eop, b.err, b.empty, b.data};
    endfunction

    task automatic model_accept();
        mbeat_t b;
        b.sop = in_sop; b.eop = in_eop; b.err = in_error; b.empty = in_empty; b.data = in_data;
        if (m_mode == 1) begin
            if (b.sop) begin b.sop = 1'b0; b.err = 1'b1; end
            if (m_dest) qp.push_back(b); else qh.push_back(b);
            if (b.eop) m_mode = 0;
        end else if (b.sop) begin
            m_dest = i_payload_in;
            if (m_dest) qp.push_back(b); else qh.push_back(b);
            m_mode = b.eop ? 0 : 1;
        end else begin
            exp_drop++;
            m_mode = b.eop ? 0 : 2;
        end
    endtask

    // One clock cycle: compare outputs against the model, then advance.
    task automatic tick();
        mbeat_t b;
        if (rand_rdy) begin
            hdr_rdy = ($urandom % 4) != 0;
            pay_rdy = ($urandom % 4) != 0;
        end
        #1;
        check("hdr_valid", 80'(hv), 80'(qh.size() != 0));
        check("pay_valid", 80'(pv), 80'(qp.size() != 0));
        if (qh.size() != 0 && hdr_rdy) begin
            b = qh.pop_front();
            check("hdr_beat", {10'd0, hs, he, herr, hemp, hdat}, pk(b));
            if (b.eop) exp_hdr++;
        end
        if (qp.size() != 0 && pay_rdy) begin
            b = qp.pop_front();
            check("pay_beat", {10'd0, ps, pe, perr, pemp, pdat}, pk(b));
            if (b.eop) exp_pay++;
        end
        if (in_valid && in_ready) model_accept();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic sop, input logic eop, input logic tag,
                        input logic [DW-1:0] data, input logic [EW-1:0] empty,
                        input logic err, output int waits);
        in_sop = sop; in_eop = eop; i_payload_in = tag; in_data = data;
        in_empty = empty; in_error = err; in_valid = 1'b1;
        waits = 0;
        while (!in_ready && waits < 200) begin
            tick();
            waits++;
        end
        check("send_accept", 80'(in_ready), 80'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qh.size() != 0 || qp.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        tick();
        check("drain_empty", 80'(qh.size() + qp.size()), 80'd0);
        check("hdr_pkts", 80'(o_hdr_pkts), 80'(exp_hdr[15:0]));
        check("pay_pkts", 80'(o_pay_pkts), 80'(exp_pay[15:0]));
        check("drop_beats", 80'(o_drop_beats), 80'(exp_drop[15:0]));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        qh.delete(); qp.delete();
        m_mode = 0; exp_hdr = 0; exp_pay = 0; exp_drop = 0;
        check("rst_in_ready", 80'(in_ready), 80'd0);
        check("rst_valids", 80'({hv, pv}), 80'd0);
        check("rst_counters", 80'({o_hdr_pkts, o_pay_pkts, o_drop_beats}), 80'd0);
        check("rst_fields", {10'd0, hs, he, herr, hemp, hdat}, 80'd0);
        check("rst_pfields", {10'd0, ps, pe, perr, pemp, pdat}, 80'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ready_before_clk", 80'(in_ready), 80'd0);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_clk", 80'(in_ready), 80'd1);
    endtask

    initial begin
        #2;
        do_reset();

        // header packet then payload packet, back-to-back with no bubbles
        wsum = 0;
        send(1, 0, 0, 64'h11, 0, 0, w); wsum += w;
        check("latency_valid", 80'(hv), 80'd1);
        check("latency_data", 80'(hdat), 80'h11);
        send(0, 0, 0, 64'h22, 0, 0, w); wsum += w;
        send(0, 1, 0, 64'h33, 0, 0, w); wsum += w;
        for (int i = 0; i < 4; i++) begin
            send(i == 0, i == 3, 1, 64'hA0 + 64'(i), 3'(i), 0, w);
            wsum += w;
        end
        check("no_bubble", 80'(wsum), 80'd0);
        drain();
        check("first_hdr_pkts", 80'(o_hdr_pkts), 80'd1);
        check("first_pay_pkts", 80'(o_pay_pkts), 80'd1);

        // stalled payload output fills its buffer after two beats
        pay_rdy = 1'b0;
        send(1, 0, 1, 64'hB0, 0, 0, w);
        send(0, 0, 1, 64'hB1, 0, 0, w);
        check("stall_ready_low", 80'(in_ready), 80'd0);
        check("stall_head", 80'(pdat), 80'hB0);
        tick(); tick(); tick();
        pay_rdy = 1'b1;
        for (int i = 2; i < 10; i++) send(0, i == 9, 1, 64'hB0 + 64'(i), 0, 0, w);
        drain();
        check("stall_no_drop", 80'(o_drop_beats), 80'd0);

        // orphan beats without sop are discarded, then a single-beat header
        send(0, 0, 0, 64'hD0, 0, 0, w);
        send(0, 0, 1, 64'hD1, 0, 0, w);
        send(0, 1, 0, 64'hD2, 0, 0, w);
        send(1, 1, 0, 64'h55, 0, 0, w);
        drain();
        check("drop_count", 80'(o_drop_beats), 80'd3);

        // unexpected sop mid-packet is forwarded as an errored continuation
        send(1, 0, 0, 64'hE1, 0, 0, w);
        send(1, 0, 0, 64'hE2, 0, 0, w);
        check("midsop_sop", 80'(hs), 80'd0);
        check("midsop_err", 80'(herr), 80'd1);
        check("midsop_data", 80'(hdat), 80'hE2);
        send(0, 0, 0, 64'hE3, 0, 0, w);
        send(0, 1, 0, 64'hE4, 0, 0, w);
        send(1, 1, 1, 64'h77, 0, 0, w);
        drain();

        // blocked header output does not slow a payload packet
        hdr_rdy = 1'b0;
        wsum = 0;
        for (int i = 0; i < 5; i++) begin
            send(i == 0, i == 4, 1, 64'hC0 + 64'(i), 0, i == 2, w);
            wsum += w;
        end
        check("pay_full_rate", 80'(wsum), 80'd0);
        check("hdr_untouched", 80'(hv), 80'd0);
        hdr_rdy = 1'b1;
        drain();

        // reset in the middle of a payload packet with two beats buffered
        pay_rdy = 1'b0;
        send(1, 0, 1, 64'hF0, 0, 0, w);
        send(0, 0, 1, 64'hF1, 0, 0, w);
        check("pre_reset_buffered", 80'(pv), 80'd1);
        do_reset();
        pay_rdy = 1'b1;
        for (int i = 0; i < 3; i++) send(i == 0, i == 2, 0, 64'h90 + 64'(i), 0, 0, w);
        drain();

        // randomized packets with random back-pressure and malformed traffic
        rand_rdy = 1'b1;
        for (int p = 0; p < 60; p++) begin
            int   len;
            logic tag, orphan;
            len    = $urandom_range(1, 5);
            tag    = 1'($urandom);
            orphan = ($urandom % 8) == 0;
            for (int b = 0; b < len; b++) begin
                logic sop;
                sop = (b == 0) ? !orphan : (($urandom % 8) == 0);
                if (($urandom % 4) == 0) tick();
                send(sop, b == len - 1, tag, {$urandom, $urandom}, 3'($urandom), 1'($urandom % 2), w);
            end
        end
        rand_rdy = 1'b0;
        hdr_rdy = 1'b1;
        pay_rdy = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/split_from_noc.md
# split_from_noc

Receive-side demultiplexer for the packet parser's NoC link. It takes a single Avalon-ST stream arriving from the NoC, which carries complete header packets and payload packets interleaved at packet granularity, and steers each packet to either a header output or a payload output. Each output has a 2-entry registered buffer, so back-pressure on one output stalls the NoC input without combinational ready paths. Malformed traffic is discarded, and it is counted.

## Interface
- DATA_WIDTH, 64, data bus width in bits; EMPTY_W = $clog2(DATA_WIDTH/8) is derived.
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- in  avalonST.sink  valid/ready/sop/eop/error/empty[EMPTY_W]/data[DATA_WIDTH]  stream from the NoC; ready latency 0.
- i_payload_in  in  1  packet-type tag; 1 = payload packet, 0 = header packet; sampled only on an accepted sop beat.
- out_header  avalonST.src  same fields  header packets; ready latency 0.
- out_payload  avalonST.src  same fields  payload packets; ready latency 0.
- o_hdr_pkts  out  16  count of header eop beats delivered on out_header; wraps.
- o_pay_pkts  out  16  count of payload eop beats delivered on out_payload; wraps.
- o_drop_beats  out  16  count of input beats discarded; wraps.

## Operation
- Accept condition: in.valid && in.ready.
- Each output has a 2-entry FIFO holding {sop, eop, error, empty, data} and a registered occupancy cnt (0..2).
- out_X.valid = (cnt_X != 0). The out_X fields come from the head entry. An entry pops when out_X.valid && out_X.ready.
- in.ready is a function of registered state only:
  - IDLE and DROP: (cnt_H < 2) && (cnt_P < 2).
  - HEAD: cnt_H < 2.
  - PAYLOAD: cnt_P < 2.
- Push and pop on the same FIFO in the same cycle is legal at cnt 1; cnt stays unchanged. Push never occurs at cnt 2.
- The FSM has four states: IDLE, HEAD, PAYLOAD, DROP.
  - IDLE, accepted beat with sop:
    - Push the beat to the destination selected by i_payload_in.
    - If eop, stay IDLE (single-beat packet). Otherwise go to HEAD (tag 0) or PAYLOAD (tag 1).
  - IDLE, accepted beat without sop:
    - Discard the beat and increment o_drop_beats.
    - If eop, stay IDLE. Otherwise go to DROP.
  - HEAD/PAYLOAD, accepted beat:
    - Push the beat to the current destination.
    - An unexpected sop mid-packet is forwarded with sop forced to 0 and error forced to 1, and treated as a continuation beat.
    - eop returns the FSM to IDLE.
  - DROP, accepted beat without sop:
    - Discard the beat and increment o_drop_beats.
    - eop returns the FSM to IDLE.
  - DROP, accepted beat with sop: handled exactly as in IDLE; it starts a new packet.
- The error and empty fields pass through unchanged, except for the forced error above.
- Packet order within each output is preserved. Packets are never split across outputs.
- o_hdr_pkts and o_pay_pkts increment on output pop of an eop entry, not on input push.

## Timing
- Reset (async assert, sync release) forces:
  - FSM = IDLE and all cnt = 0.
  - out_header.valid = out_payload.valid = 0, and all out data/sop/eop/error/empty = 0.
  - All counters = 0.
  - in.ready = 0 while reset_n is low.
- in.ready = 1 on the first clk after reset_n deasserts.
- Reset mid-packet discards all buffered beats. No partial packet is emitted afterwards.
- Latency: a beat accepted in cycle N is presented on its output in cycle N+1 when that FIFO was empty.
- Throughput: one beat per cycle sustained when the destination ready is held high.
- Stall behaviour:
  - When out_X.ready drops, cnt_X reaches 2 after at most 2 further accepted beats. in.ready then falls in the following cycle.
  - No beat is lost. No beat is duplicated.
- No combinational path exists from out_X.ready or in.valid to in.ready.
- Back-to-back packets to different outputs: the eop of the first packet and the sop of the second are accepted on consecutive cycles with no bubble, provided both FIFOs have space.

## Test plan
- Header packet of 3 beats (tag 0, data 0x11/0x22/0x33), then payload packet of 4 beats (tag 1) -> out_header emits 0x11..0x33 with sop/eop on the first/last beat; out_payload emits its 4 beats; o_hdr_pkts = 1, o_pay_pkts = 1.
- 10-beat payload packet with out_payload.ready held low for cycles 3-7 -> in.ready falls after 2 buffered beats; all 10 beats delivered in order once ready returns; o_drop_beats = 0.
- Beat without sop in IDLE, followed by 2 more beats ending in eop, then a valid 1-beat header (sop = eop = 1) -> o_drop_beats = 3, and the header is delivered with o_hdr_pkts = 1.
- sop asserted on beat 2 of a 4-beat header packet -> out_header beat 2 has sop = 0 and error = 1; the packet ends at the original eop; FSM returns to IDLE.
- out_header.ready low while a payload packet arrives in IDLE (cnt_H = 0) -> payload flows at full rate; header FIFO untouched.
- reset_n pulsed low in the middle of a 6-beat payload packet with 2 beats buffered -> both outputs invalid and all counters 0; after release the next sop packet is delivered intact.
